ppc_insn_cracker: RTL and testbench
===================================

// Module: ppc_insn_cracker
// PURPOSE
//  Streaming cracker that splits PowerPC update-form and multiple-word load/store instructions into simple micro-ops
//  (base load/store plus addi/add base update; lmw/stmw into lwz/stw sequences).
//  Sits between instruction fetch and decode; uses valid/ready on both sides, and in_ready replaces the old ext_stall.
//  Adds X-form update, lmw/stmw sequencing, per-class enables, sequence-length cap, hazard-safe ordering and flush.
// PARAMETERS
//  EN_UPDATE  1   1: crack D-form (opcode 33/35/37/39/41/43/45) and X-form (op31 XO 55/119/183/247/311/375/439) updates
//  EN_MULTI   1   1: crack lmw (op46) / stmw (op47)
//  MAX_SEQ    32  max micro-ops per lmw/stmw (1..32); longer sequences pass through uncracked
// PORTS
//  clk          in   1   clock, all state on posedge
//  rst_n        in   1   synchronous active-low reset
//  flush        in   1   synchronous: drop the current sequence and output register
//  in_valid     in   1   upstream instruction valid
//  in_insn      in   32  instruction word
//  in_pc        in   32  instruction address
//  in_ready     out  1   accepting; in_valid&in_ready = accept
//  out_valid    out  1   micro-op valid
//  out_insn     out  32  micro-op word
//  out_pc       out  32  PC of parent instruction (same for all its micro-ops)
//  out_last     out  1   final micro-op of parent
//  out_cracked  out  1   micro-op was generated (0 = passthrough)
//  out_ready    in   1   downstream accepts; out_valid&out_ready = transfer
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE; out_valid=0, out_insn=0, out_pc=0, out_last=0, out_cracked=0; in_ready=0 while
//  rst_n=0, and in_ready=1 on the first cycle after reset.
//  Output register advances when !out_valid | out_ready. Latency: accept at edge N -> first micro-op valid after edge N.
//  in_ready = (state==IDLE) & (!out_valid | out_ready) & !flush. Single-op instructions sustain 1/cycle.
//  FSM: IDLE --accept of cracked insn--> SEQ (captures insn/pc, idx); SEQ emits one micro-op per advance;
//   SEQ --last micro-op loaded--> IDLE. Passthrough insns load directly from IDLE, out_last=1, out_cracked=0.
//  D-form update (rA!=0, and for loads rA!=rD): op1 = {op-1, rS/rD, rA, d}; op2 = addi rA,rA,d = {6'd14, rA, rA, d}.
//  X-form update (same rA rules): op1 = insn with XO-32; op2 = add rA,rA,rB = {6'd31, rA, rA, rB, 10'd266, 1'b0}.
//  Invalid forms (rA==0, load with rA==rD) and any class that is disabled: passthrough unchanged.
//  lmw/stmw rD..31: micro-op k = {op46?6'd32:6'd36, rD+k, rA, d+4k} (16-bit wrap of the offset field).
//   - Passthrough if 32-rD > MAX_SEQ, or if d+4*(31-rD) overflows signed 16 bits.
//   - lmw with rD<=rA (rA!=0): the lwz to rA is skipped in order and emitted last.
//  out_last=1 only on the final micro-op; out_pc is held constant across the sequence.
//  Back-pressure: out_* are held stable while out_valid & !out_ready; the sequence index does not advance.
//  flush (or rst_n=0) mid-sequence: next edge -> IDLE, out_valid=0; the partial sequence is discarded (flush wins over accept).
// TESTING
//  1 reset: assert rst_n=0 two cycles while in_valid=1 -> out_valid=0, in_ready=0; after release in_ready=1
//  2 9421ffe0 (stwu r1,-32(r1)) pc=0x100 -> 9021ffe0 (last=0), 3821ffe0 (last=1), both pc=0x100, cracked=1;
//    87fe0004 -> 83fe0004, 3bde0004
//  3 7c1f006e (lwzux r0,r31,r0) -> 7c1f002e, 7fff0214; 7c0802a6 (mflr) -> 7c0802a6, last=1, cracked=0, no stall
//  4 bbc10018 (lmw r30,24(r1)) -> 83c10018, 83e1001c(last); bf010010 (stmw) -> 8 ops 93010010..93e1002c step +4,
//    in_ready=0 for 7 cycles; lmw r29,0(r30) -> r29, r31, then r30 last
//  5 out_ready toggled randomly during stmw -> exact 8-op sequence, no drop/dup, out_* stable while stalled;
//    MAX_SEQ=4 -> stmw passes through
//  6 flush on 3rd micro-op of stmw -> out_valid=0 next cycle, in_ready=1, next insn 9421ffe0 cracks correctly

Source files
------------

// File: rtl/ppc_insn_cracker.sv
// Streaming cracker: splits PowerPC update-form and lmw/stmw instructions into simple micro-ops.
// One output register with valid/ready handshaking; in_ready is high only while idle and the register can advance.
module ppc_insn_cracker #(
  parameter bit          EN_UPDATE = 1'b1,
  parameter bit          EN_MULTI  = 1'b1,
  parameter int unsigned MAX_SEQ   = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [31:0] in_insn,
  input  logic [31:0] in_pc,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_insn,
  output logic [31:0] out_pc,
  output logic        out_last,
  output logic        out_cracked,
  input  logic        out_ready
);

  localparam logic [5:0] MAX_SEQ_W = 6'(MAX_SEQ);

  typedef enum logic {S_IDLE, S_SEQ} state_t;

  state_t      r_state;
  logic [31:0] r_insn;
  logic [5:0]  r_pos;

  logic        w_adv, w_idle;
  logic [31:0] w_src;
  logic [5:0]  w_opc;
  logic [4:0]  w_rt, w_ra, w_rb;
  logic [9:0]  w_xo;
  logic [15:0] w_d;
  logic        w_dupd, w_xupd, w_load, w_upd_ok;
  logic        w_lmw, w_multi, w_multi_ok, w_reorder, w_crack;
  logic [5:0]  w_nops;
  logic [17:0] w_end;
  logic [5:0]  w_pos, w_nxt, w_reg;
  logic [4:0]  w_k;
  logic [31:0] w_uop;
  logic        w_ulast;

  function automatic logic [5:0] skip_ra(input logic [5:0] r, input logic reorder, input logic [4:0] ra);
    return (reorder && r == {1'b0, ra}) ? r + 6'd1 : r;
  endfunction

  assign w_adv    = !out_valid || out_ready;
  assign w_idle   = (r_state == S_IDLE);
  assign in_ready = rst_n && w_idle && w_adv && !flush;

  // Decode the incoming word while idle, the captured parent while sequencing.
  assign w_src = w_idle ? in_insn : r_insn;
  assign w_opc = w_src[31:26];
  assign w_rt  = w_src[25:21];
  assign w_ra  = w_src[20:16];
  assign w_rb  = w_src[15:11];
  assign w_xo  = w_src[10:1];
  assign w_d   = w_src[15:0];

  always_comb begin
    w_dupd = 1'b0;
    w_xupd = 1'b0;
    w_load = 1'b0;
    case (w_opc)
      6'd33, 6'd35, 6'd41, 6'd43: begin w_dupd = 1'b1; w_load = 1'b1; end
      6'd37, 6'd39, 6'd45:        w_dupd = 1'b1;
      6'd31: begin
        case (w_xo)
          10'd55, 10'd119, 10'd311, 10'd375: begin w_xupd = 1'b1; w_load = 1'b1; end
          10'd183, 10'd247, 10'd439:         w_xupd = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign w_upd_ok = EN_UPDATE && (w_dupd || w_xupd) && (w_ra != 5'd0) && !(w_load && w_ra == w_rt);

  // Last offset is d + 4*(31-rD); it must stay within signed 16 bits.
  assign w_lmw      = (w_opc == 6'd46);
  assign w_multi    = EN_MULTI && (w_lmw || w_opc == 6'd47);
  assign w_nops     = 6'd32 - {1'b0, w_rt};
  assign w_end      = {{2{w_d[15]}}, w_d} + {11'd0, ~w_rt, 2'b00};
  assign w_multi_ok = w_multi && (w_nops <= MAX_SEQ_W) && !(!w_end[17] && (|w_end[16:15]));
  assign w_reorder  = w_lmw && (w_ra != 5'd0) && (w_rt <= w_ra);
  assign w_crack    = w_upd_ok || w_multi_ok;

  always_comb begin
    w_pos   = w_idle ? (w_multi ? skip_ra({1'b0, w_rt}, w_reorder, w_ra) : 6'd0) : r_pos;
    w_uop   = '0;
    w_ulast = 1'b0;
    w_nxt   = w_pos + 6'd1;
    w_reg   = w_pos;
    w_k     = '0;
    if (w_upd_ok) begin
      w_ulast = w_pos[0];
      if (!w_pos[0])
        w_uop = w_dupd ? {w_opc - 6'd1, w_src[25:0]} : {w_src[31:11], w_xo - 10'd32, w_src[0]};
      else
        w_uop = w_dupd ? {6'd14, w_ra, w_ra, w_d} : {6'd31, w_ra, w_ra, w_rb, 10'd266, 1'b0};
    end else begin
      // Position walks rD..31 skipping a deferred rA; position 32 emits that rA last.
      w_reg   = w_pos[5] ? {1'b0, w_ra} : w_pos;
      w_nxt   = skip_ra(w_pos + 6'd1, w_reorder, w_ra);
      w_ulast = w_pos[5] || (w_nxt[5] && !w_reorder);
      w_k     = w_reg[4:0] - w_rt;
      w_uop   = {w_lmw ? 6'd32 : 6'd36, w_reg[4:0], w_ra, w_d + {9'd0, w_k, 2'b00}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_insn      <= '0;
      r_pos       <= '0;
      out_valid   <= 1'b0;
      out_insn    <= '0;
      out_pc      <= '0;
      out_last    <= 1'b0;
      out_cracked <= 1'b0;
    end else if (flush) begin
      r_state   <= S_IDLE;
      out_valid <= 1'b0;
    end else if (w_adv) begin
      if (!w_idle) begin
        out_valid <= 1'b1;
        out_insn  <= w_uop;
        out_last  <= w_ulast;
        r_pos     <= w_nxt;
        if (w_ulast) r_state <= S_IDLE;
      end else if (in_valid) begin
        out_valid <= 1'b1;
        out_pc    <= in_pc;
        if (w_crack) begin
          out_insn    <= w_uop;
          out_last    <= w_ulast;
          out_cracked <= 1'b1;
          if (!w_ulast) begin
            r_state <= S_SEQ;
            r_insn  <= in_insn;
            r_pos   <= w_nxt;
          end
        end else begin
          out_insn    <= in_insn;
          out_last    <= 1'b1;
          out_cracked <= 1'b0;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ppc_insn_cracker.sv
// Randomized bench for ppc_insn_cracker against a list-based reference model and scoreboard.
module tb_ppc_insn_cracker;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_valid, in_ready, out_valid, out_last, out_cracked, out_ready;
  logic [31:0] in_insn, in_pc, out_insn, out_pc;
  logic        flush_b, in_valid_b, in_ready_b, out_valid_b, out_last_b, out_cracked_b, out_ready_b;
  logic [31:0] in_insn_b, in_pc_b, out_insn_b, out_pc_b;

  ppc_insn_cracker u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_insn(in_insn), .in_pc(in_pc),
    .in_ready(in_ready), .out_valid(out_valid), .out_insn(out_insn), .out_pc(out_pc),
    .out_last(out_last), .out_cracked(out_cracked), .out_ready(out_ready)
  );

  ppc_insn_cracker #(.EN_UPDATE(1'b0), .EN_MULTI(1'b1), .MAX_SEQ(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush_b), .in_valid(in_valid_b), .in_insn(in_insn_b), .in_pc(in_pc_b),
    .in_ready(in_ready_b), .out_valid(out_valid_b), .out_insn(out_insn_b), .out_pc(out_pc_b),
    .out_last(out_last_b), .out_cracked(out_cracked_b), .out_ready(out_ready_b)
  );

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc;
    logic        last;
    logic        cracked;
  } uop_t;

  uop_t        exp_q[$];
  uop_t        mdl_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  function automatic logic [31:0] mw(input int op, input int r, input int ra, input int rt, input int d);
    logic [15:0] off;
    off = 16'(d + 4 * (r - rt));
    return {(op == 46) ? 6'd32 : 6'd36, 5'(r), 5'(ra), off};
  endfunction

  // Expected micro-op list for one parent instruction, straight from the cracking rules.
  function automatic void model(input logic [31:0] insn, input logic [31:0] pc,
                                input bit en_upd, input bit en_mul, input int max_seq);
    int op, rt, ra, rb, xo, d;
    bit load, reorder;
    logic [31:0] ops[$];
    uop_t u;
    op = int'(insn[31:26]); rt = int'(insn[25:21]); ra = int'(insn[20:16]);
    rb = int'(insn[15:11]); xo = int'(insn[10:1]); d = int'($signed(insn[15:0]));
    if (en_upd && (op inside {33, 35, 37, 39, 41, 43, 45})) begin
      load = op inside {33, 35, 41, 43};
      if (ra != 0 && !(load && ra == rt)) begin
        ops.push_back(insn - 32'h0400_0000);
        ops.push_back({6'd14, 5'(ra), 5'(ra), insn[15:0]});
      end
    end else if (en_upd && op == 31 && (xo inside {55, 119, 183, 247, 311, 375, 439})) begin
      load = xo inside {55, 119, 311, 375};
      if (ra != 0 && !(load && ra == rt)) begin
        ops.push_back(insn - 32'd64);
        ops.push_back({6'd31, 5'(ra), 5'(ra), 5'(rb), 10'd266, 1'b0});
      end
    end else if (en_mul && (op inside {46, 47})) begin
      if ((32 - rt) <= max_seq && d + 4 * (31 - rt) <= 32767) begin
        reorder = (op == 46) && ra != 0 && rt <= ra;
        for (int r = rt; r < 32; r++)
          if (!(reorder && r == ra)) ops.push_back(mw(op, r, ra, rt, d));
        if (reorder) ops.push_back(mw(op, ra, ra, rt, d));
      end
    end
    mdl_q.delete();
    if (ops.size() == 0) begin
      u.insn = insn; u.pc = pc; u.last = 1'b1; u.cracked = 1'b0;
      mdl_q.push_back(u);
    end else begin
      foreach (ops[i]) begin
        u.insn = ops[i]; u.pc = pc; u.last = (i == ops.size() - 1); u.cracked = 1'b1;
        mdl_q.push_back(u);
      end
    end
  endfunction

  function automatic bit rnd_ready(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  // One clock of the main DUT, starting and ending at a falling edge.
  task automatic cycle(input bit v, input logic [31:0] insn, input logic [31:0] pc,
                       input bit ordy, input bit fl, output bit acc);
    bit ov;
    uop_t e;
    in_valid = v; in_insn = insn; in_pc = pc; out_ready = ordy; flush = fl;
    #1;
    ov = out_valid;
    check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    check("in_ready", 32'(in_ready), 32'(!fl && (exp_q.size() == 0 || (exp_q.size() == 1 && ordy))));
    if (ov && exp_q.size() != 0) begin
      e = exp_q[0];
      check("out_insn", out_insn, e.insn);
      check("out_pc", out_pc, e.pc);
      check("out_last", 32'(out_last), 32'(e.last));
      check("out_cracked", 32'(out_cracked), 32'(e.cracked));
    end
    acc = v && in_ready;
    @(posedge clk);
    if (fl) exp_q.delete();
    else begin
      if (ov && ordy && exp_q.size() != 0) void'(exp_q.pop_front());
      if (acc) begin
        model(insn, pc, 1'b1, 1'b1, 32);
        foreach (mdl_q[i]) exp_q.push_back(mdl_q[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] insn, input logic [31:0] pc, input int pct);
    bit acc = 1'b0;
    int guard = 0;
    while (!acc && guard < 300) begin
      cycle(1'b1, insn, pc, rnd_ready(pct), 1'b0, acc);
      guard++;
    end
    check("send_accept", 32'(acc), 32'd1);
  endtask

  task automatic drain(input int pct);
    bit acc;
    int guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      cycle(1'b0, '0, '0, rnd_ready(pct), 1'b0, acc);
      guard++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Single instruction through the second instance with out_ready held high.
  task automatic run_b(input logic [31:0] insn);
    int guard = 0;
    model(insn, 32'h200, 1'b0, 1'b1, 4);
    in_valid_b = 1'b1; in_insn_b = insn; in_pc_b = 32'h200;
    #1;
    while (!in_ready_b && guard < 20) begin @(negedge clk); #1; guard++; end
    check("b_accept", 32'(in_ready_b), 32'd1);
    @(negedge clk);
    in_valid_b = 1'b0;
    for (int k = 0; k < mdl_q.size(); k++) begin
      #1;
      check("b_valid", 32'(out_valid_b), 32'd1);
      check("b_insn", out_insn_b, mdl_q[k].insn);
      check("b_pc", out_pc_b, mdl_q[k].pc);
      check("b_last", 32'(out_last_b), 32'(mdl_q[k].last));
      check("b_cracked", 32'(out_cracked_b), 32'(mdl_q[k].cracked));
      @(negedge clk);
    end
    #1;
    check("b_idle", 32'(out_valid_b), 32'd0);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_insn();
    logic [31:0] w;
    w = $urandom();
    case ($urandom_range(0, 5))
      0: w[31:26] = 6'(33 + 2 * $urandom_range(0, 6));
      1: begin w[31:26] = 6'd31; w[10:1] = 10'(55 + 64 * $urandom_range(0, 6)); end
      2, 3: begin
        w[31:26] = 6'($urandom_range(46, 47));
        w[25:21] = 5'($urandom_range(20, 31));
        w[15:0]  = $urandom_range(0, 1) ? 16'($urandom_range(0, 64)) : 16'(32767 - $urandom_range(0, 60));
      end
      default: ;
    endcase
    if ($urandom_range(0, 4) == 0) w[20:16] = w[25:21];
    else if ($urandom_range(0, 6) == 0) w[20:16] = 5'd0;
    return w;
  endfunction

  initial begin
    bit acc;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_insn = 32'h9421ffe0; in_pc = '0; out_ready = 1'b1;
    flush_b = 1'b0; in_valid_b = 1'b0; in_insn_b = '0; in_pc_b = '0; out_ready_b = 1'b1;

    repeat (2) begin
      @(posedge clk); #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
    end
    check("rst_out_insn", out_insn, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_cracked", 32'(out_cracked), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    check("rst_release_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    send(32'h9421ffe0, 32'h100, 100);
    send(32'h87fe0004, 32'h104, 100);
    send(32'h7c1f006e, 32'h108, 100);
    send(32'h7c0802a6, 32'h10c, 100);
    send(32'hbbc10018, 32'h110, 100);
    send(32'hbf010010, 32'h114, 100);
    send(32'hbbbe0000, 32'h118, 100);
    drain(100);

    send(32'hbf010010, 32'h300, 50);
    drain(50);

    send(32'hbf010010, 32'h400, 100);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);
    cycle(1'b1, 32'h9421ffe0, 32'h404, 1'b1, 1'b1, acc);
    check("flush_blocks_accept", 32'(acc), 32'd0);
    send(32'h9421ffe0, 32'h408, 100);
    drain(100);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) cycle(1'b0, '0, '0, rnd_ready(70), 1'b0, acc);
      send(rand_insn(), $urandom() & 32'hffff_fffc, 70);
    end
    drain(70);

    run_b(32'hbf010010);
    run_b(32'hbb810000);
    run_b(32'hbb610000);
    run_b(32'h9421ffe0);
    run_b(32'hbf817ff4);
    run_b(32'hbf817ff3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
